// File: rtl/axis_bram_pkg.sv
// ----------------------------------------------------------------------------
// axis_bram_pkg : shared FSM encodings and byte-enable constants for axis_bram
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package axis_bram_pkg;

  typedef enum logic [0:0] {
    E_AXIS_BRAM_RSP_CLEAR = 1'b0,
    E_AXIS_BRAM_RSP_READY = 1'b1
  } axis_bram_rsp_state_e;

  // Wide enough for any supported data width; users slice the low DATA_WIDTH/8 bits.
  localparam int           C_AXIS_BRAM_BE_MAX_WIDTH = 128;
  localparam logic [127:0] C_AXIS_BRAM_BE_ALL_ONES  = {128{1'b1}};
  localparam logic [127:0] C_AXIS_BRAM_BE_ALL_ZEROS = {128{1'b0}};

endpackage

`default_nettype wire

// File: rtl/axis_bram_rsp_delay.sv
// ----------------------------------------------------------------------------
// axis_bram_rsp_delay : valid+data read-response pipeline, C_LATENCY stages
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module axis_bram_rsp_delay #(
  parameter int C_LATENCY = 1,
  parameter int C_WIDTH   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [C_WIDTH-1:0] in_data,
  output logic               out_valid,
  output logic [C_WIDTH-1:0] out_data
);

  logic [C_LATENCY-1:0] valid_q, valid_d;
  logic [C_WIDTH-1:0]   data_q [C_LATENCY];
  logic [C_WIDTH-1:0]   data_d [C_LATENCY];

  // Each stage only loads when the stage feeding it is valid, so the last
  // stage keeps the most recently completed response.
  always_comb begin
    valid_d[0] = in_valid;
    data_d[0]  = in_valid ? in_data : data_q[0];
    for (int i = 1; i < C_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign out_valid = valid_q[C_LATENCY-1];
  assign out_data  = data_q[C_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/axis_bram_responder.sv
// ----------------------------------------------------------------------------
// axis_bram_responder : BRAM-port memory responder with clear FSM, range check
//                       and saturating access counters
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module axis_bram_responder
  import axis_bram_pkg::*;
#(
  parameter int C_AXIS_BRAM_ADDR_WIDTH   = 12,
  parameter int C_AXIS_BRAM_DATA_WIDTH   = 64,
  parameter int C_AXIS_BRAM_DEPTH        = 4096,
  parameter int C_AXIS_BRAM_READ_LATENCY = 1,
  parameter int C_AXIS_BRAM_CNT_WIDTH    = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                bram_en,
  input  logic [C_AXIS_BRAM_DATA_WIDTH/8-1:0] bram_we,
  input  logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]   bram_addr,
  input  logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   bram_din,
  output logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   bram_dout,
  input  logic                                ctrl_clear,
  output logic                                stat_busy,
  output logic                                stat_err,
  input  logic                                stat_err_clr,
  output logic [C_AXIS_BRAM_CNT_WIDTH-1:0]    stat_rd_count,
  output logic [C_AXIS_BRAM_CNT_WIDTH-1:0]    stat_wr_count
);

  localparam int C_AW    = C_AXIS_BRAM_ADDR_WIDTH;
  localparam int C_DW    = C_AXIS_BRAM_DATA_WIDTH;
  localparam int C_NB    = C_DW / 8;
  localparam int C_CW    = C_AXIS_BRAM_CNT_WIDTH;
  localparam int C_IDX_W = (C_AXIS_BRAM_DEPTH > 1) ? $clog2(C_AXIS_BRAM_DEPTH) : 1;

  localparam logic [C_IDX_W-1:0] C_LAST_IDX  = C_IDX_W'(C_AXIS_BRAM_DEPTH - 1);
  localparam logic [C_AW:0]      C_DEPTH_EXT = (C_AW + 1)'(C_AXIS_BRAM_DEPTH);
  localparam logic [C_NB-1:0]    C_BE_ONES   = C_AXIS_BRAM_BE_ALL_ONES[C_NB-1:0];
  localparam logic [C_NB-1:0]    C_BE_ZEROS  = C_AXIS_BRAM_BE_ALL_ZEROS[C_NB-1:0];
  localparam logic [C_CW-1:0]    C_CNT_MAX   = {C_CW{1'b1}};

  logic [C_DW-1:0] mem_q [C_AXIS_BRAM_DEPTH];

  axis_bram_rsp_state_e state_q, state_d;
  logic [C_IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic                 err_q, err_d;
  logic [C_CW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [C_CW-1:0]      wr_cnt_q, wr_cnt_d;
  logic                 had_rd_q, had_rd_d;

  logic                 busy, in_range, is_wr, req_ok, acc_wr, acc_rd;
  logic [C_IDX_W-1:0]   addr_idx;
  logic                 rsp_in_valid, rsp_valid;
  logic [C_DW-1:0]      rsp_in_data, rsp_data;
  logic [C_IDX_W-1:0]   mem_wr_idx;
  logic [C_DW-1:0]      mem_wr_data;
  logic [C_NB-1:0]      mem_wr_be;
  logic                 dout_live;

  always_comb begin
    busy         = (state_q == E_AXIS_BRAM_RSP_CLEAR);
    addr_idx     = bram_addr[C_IDX_W-1:0];
    in_range     = ({1'b0, bram_addr} < C_DEPTH_EXT);
    is_wr        = (bram_we != C_BE_ZEROS);
    req_ok       = bram_en && !busy;
    acc_wr       = req_ok && in_range && is_wr;
    acc_rd       = req_ok && in_range && !is_wr;
    // Out-of-range reads still complete, carrying zero.
    rsp_in_valid = req_ok && !is_wr;
    rsp_in_data  = in_range ? mem_q[addr_idx] : '0;

    mem_wr_idx  = addr_idx;
    mem_wr_data = bram_din;
    mem_wr_be   = acc_wr ? bram_we : C_BE_ZEROS;
    if (busy) begin
      mem_wr_idx  = clr_idx_q;
      mem_wr_data = '0;
      mem_wr_be   = C_BE_ONES;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      E_AXIS_BRAM_RSP_CLEAR: begin
        if (clr_idx_q == C_LAST_IDX) begin
          state_d = E_AXIS_BRAM_RSP_READY;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      E_AXIS_BRAM_RSP_READY: begin
        if (ctrl_clear) begin
          state_d   = E_AXIS_BRAM_RSP_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = E_AXIS_BRAM_RSP_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (stat_err_clr) begin
      err_d = 1'b0;
    end
    if (bram_en && (busy || !in_range)) begin
      err_d = 1'b1;
    end
    rd_cnt_d  = (acc_rd && (rd_cnt_q != C_CNT_MAX)) ? rd_cnt_q + 1'b1 : rd_cnt_q;
    wr_cnt_d  = (acc_wr && (wr_cnt_q != C_CNT_MAX)) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    dout_live = had_rd_q || rsp_valid;
    had_rd_d  = dout_live;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= E_AXIS_BRAM_RSP_CLEAR;
      clr_idx_q <= '0;
      err_q     <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      had_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      err_q     <= err_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      had_rd_q  <= had_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < C_NB; b++) begin
      if (mem_wr_be[b]) begin
        mem_q[mem_wr_idx][8*b +: 8] <= mem_wr_data[8*b +: 8];
      end
    end
  end

  axis_bram_rsp_delay #(
    .C_LATENCY (C_AXIS_BRAM_READ_LATENCY),
    .C_WIDTH   (C_DW)
  ) u_rsp_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rsp_in_valid),
    .in_data   (rsp_in_data),
    .out_valid (rsp_valid),
    .out_data  (rsp_data)
  );

  // The pipeline data registers are not reset, so mask them until the
  // first response after reset has completed.
  assign bram_dout     = dout_live ? rsp_data : '0;
  assign stat_busy     = busy;
  assign stat_err      = err_q;
  assign stat_rd_count = rd_cnt_q;
  assign stat_wr_count = wr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_bram_responder.sv
// ----------------------------------------------------------------------------
// tb_axis_bram_responder : directed + random bench with behavioural memory model
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_axis_bram_responder;

  localparam int AW    = 5;
  localparam int DW    = 64;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          bram_en;
  logic [NB-1:0] bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;
  logic          ctrl_clear;
  logic          stat_busy;
  logic          stat_err;
  logic          stat_err_clr;
  logic [CW-1:0] stat_rd_count;
  logic [CW-1:0] stat_wr_count;

  axis_bram_responder #(
    .C_AXIS_BRAM_ADDR_WIDTH   (AW),
    .C_AXIS_BRAM_DATA_WIDTH   (DW),
    .C_AXIS_BRAM_DEPTH        (DEPTH),
    .C_AXIS_BRAM_READ_LATENCY (LAT),
    .C_AXIS_BRAM_CNT_WIDTH    (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bram_en       (bram_en),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .bram_dout     (bram_dout),
    .ctrl_clear    (ctrl_clear),
    .stat_busy     (stat_busy),
    .stat_err      (stat_err),
    .stat_err_clr  (stat_err_clr),
    .stat_rd_count (stat_rd_count),
    .stat_wr_count (stat_wr_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: word array, cycles of clearing left, and a list of
  // read responses with the edge at which each becomes visible.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_dout;
  logic          m_err;
  int            m_rd, m_wr, m_busy, edge_no;
  int            pend_due [$];
  logic [DW-1:0] pend_data [$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dout", bram_dout, m_dout);
    chk("busy", DW'(stat_busy), DW'(m_busy > 0));
    chk("err", DW'(stat_err), DW'(m_err));
    chk("rd_count", DW'(stat_rd_count), DW'(m_rd));
    chk("wr_count", DW'(stat_wr_count), DW'(m_wr));
  endtask

  task automatic model_reset();
    m_dout = '0;
    m_err  = 1'b0;
    m_rd   = 0;
    m_wr   = 0;
    m_busy = DEPTH;
    pend_due.delete();
    pend_data.delete();
  endtask

  task automatic model_edge();
    logic set_err;
    set_err = 1'b0;
    edge_no++;
    if (reset) return;
    if (m_busy > 0) begin
      if (bram_en) set_err = 1'b1;
      m_busy--;
      if (m_busy == 0) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else begin
      if (bram_en) begin
        if (int'(bram_addr) >= DEPTH) begin
          set_err = 1'b1;
          if (bram_we == '0) begin
            pend_due.push_back(edge_no + LAT - 1);
            pend_data.push_back('0);
          end
        end else if (bram_we != '0) begin
          for (int b = 0; b < NB; b++)
            if (bram_we[b]) m_mem[bram_addr][8*b +: 8] = bram_din[8*b +: 8];
          if (m_wr < CMAX) m_wr++;
        end else begin
          pend_due.push_back(edge_no + LAT - 1);
          pend_data.push_back(m_mem[bram_addr]);
          if (m_rd < CMAX) m_rd++;
        end
      end
      if (ctrl_clear) m_busy = DEPTH;
    end
    if (stat_err_clr) m_err = 1'b0;
    if (set_err) m_err = 1'b1;
    while (pend_due.size() > 0 && pend_due[0] == edge_no) begin
      m_dout = pend_data.pop_front();
      void'(pend_due.pop_front());
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic en, input logic [NB-1:0] we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] din, input logic clr, input logic eclr);
    bram_en      = en;
    bram_we      = we;
    bram_addr    = addr;
    bram_din     = din;
    ctrl_clear   = clr;
    stat_err_clr = eclr;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    idle();
    while (stat_busy && n < 100) begin
      cycle();
      n++;
    end
    chk(tag, DW'(n), DW'(DEPTH));
  endtask

  logic [DW-1:0] rec [10];

  initial begin
    edge_no = 0;
    idle();
    model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    reset = 1'b0;
    #2;
    do_reset();
    wait_ready("busy_after_reset");

    // Every word reads zero after the power-up clear.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, '0, AW'(i), '0, 1'b0, 1'b0);
      cycle();
    end
    idle();
    for (int i = 0; i < LAT; i++) cycle();

    // Full write then immediate read; check latency and hold.
    drive(1'b1, 8'hFF, 5'd5, 64'h1122334455667788, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 8'h00, 5'd5, '0, 1'b0, 1'b0);
    cycle();
    idle();
    cycle();
    chk("lat3_early", bram_dout, 64'h0);
    cycle();
    chk("lat3_data", bram_dout, 64'h1122334455667788);
    cycle();
    cycle();
    chk("lat3_hold", bram_dout, 64'h1122334455667788);

    // Partial byte-enable write.
    drive(1'b1, 8'h0F, 5'd5, 64'hAAAAAAAAAAAAAAAA, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 8'h00, 5'd5, '0, 1'b0, 1'b0);
    cycle();
    idle();
    for (int i = 0; i < LAT; i++) cycle();
    chk("partial", bram_dout, 64'h11223344AAAAAAAA);
    chk("wr_count_2", DW'(stat_wr_count), 64'd2);

    // Burst of back-to-back reads after a fresh reset.
    do_reset();
    wait_ready("busy_after_reset2");
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hFF, AW'(i), DW'(i * 3), 1'b0, 1'b0);
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, '0, AW'(i), '0, 1'b0, 1'b0);
      else idle();
      cycle();
      rec[i] = bram_dout;
    end
    for (int i = 0; i < 8; i++) chk($sformatf("burst_%0d", i), rec[i+2], DW'(i * 3));
    chk("rd_count_8", DW'(stat_rd_count), 64'd8);

    // Out-of-range read.
    drive(1'b1, '0, 5'd20, '0, 1'b0, 1'b0);
    cycle();
    idle();
    for (int i = 0; i < LAT; i++) cycle();
    chk("oor_dout", bram_dout, 64'h0);
    chk("oor_err", DW'(stat_err), 64'd1);
    chk("oor_rd_count", DW'(stat_rd_count), 64'd8);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    cycle();
    chk("err_clr", DW'(stat_err), 64'd0);

    // Clear pulse, access during busy, then all words zero.
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cycle();
    drive(1'b1, '0, 5'd3, '0, 1'b0, 1'b0);
    cycle();
    chk("busy_access_err", DW'(stat_err), 64'd1);
    idle();
    for (int i = 0; i < 20 && stat_busy; i++) cycle();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, '0, AW'(i), '0, 1'b0, 1'b0);
      cycle();
    end
    idle();
    for (int i = 0; i < LAT; i++) cycle();

    // Reset in the middle of a clear restarts the full sweep.
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cycle();
    idle();
    for (int i = 0; i < 5; i++) cycle();
    do_reset();
    wait_ready("busy_mid_clear_reset");

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [NB-1:0] we;
      case ($urandom_range(0, 3))
        0, 1:    we = '0;
        2:       we = '1;
        default: we = NB'($urandom);
      endcase
      drive(($urandom_range(0, 3) != 0), we, AW'($urandom_range(0, 23)),
            {$urandom, $urandom}, ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 9) == 0));
      cycle();
    end
    idle();
    for (int i = 0; i < DEPTH + LAT; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_bram_responder.md
Name: axis_bram_responder

Overview:
- Responder (memory) end of the BRAM port that axis_bram drives.
- Accepts the bram_addr/bram_en/bram_we/bram_din request bundle and returns bram_dout after a fixed, parameterised read latency.
- Backed by internal storage.
- Adds:
  - a clear-after-reset FSM,
  - out-of-range detection,
  - access counters.
- Used as the BRAM model in streaming testbenches and as a synthesizable scratch memory behind axis_bram.

Parameters:
C_AXIS_BRAM_ADDR_WIDTH, 12, width of bram_addr.
C_AXIS_BRAM_DATA_WIDTH, 64, data width; multiple of 8.
C_AXIS_BRAM_DEPTH, 4096, number of words implemented; must be <= 2**C_AXIS_BRAM_ADDR_WIDTH.
C_AXIS_BRAM_READ_LATENCY, 1, cycles from accepted read to bram_dout valid; legal range 1..4.
C_AXIS_BRAM_CNT_WIDTH, 32, width of the access counters.

Ports:
clk  input  1  sole clock; bram_clk of the initiator is tied to it.
reset  input  1  asynchronous, active-high reset.
bram_en  input  1  request strobe.
bram_we  input  DATA_WIDTH/8  per-byte write enable; all-zero with en=1 means read.
bram_addr  input  ADDR_WIDTH  word address.
bram_din  input  DATA_WIDTH  write data.
bram_dout  output  DATA_WIDTH  read data, registered.
ctrl_clear  input  1  pulse: zero the whole memory.
stat_busy  output  1  clear in progress; accesses ignored.
stat_err  output  1  sticky; set on out-of-range or busy-time access.
stat_err_clr  input  1  clears stat_err.
stat_rd_count  output  CNT_WIDTH  accepted reads, saturating.
stat_wr_count  output  CNT_WIDTH  accepted writes, saturating.

Behaviour:
- Reset (asynchronous, active-high), all outputs:
  - bram_dout=0, stat_err=0, both counters=0, read pipeline valid bits cleared.
  - FSM enters CLEAR with clear index=0, so stat_busy=1 from reset assertion onward.
  - Memory contents are not reset; they are overwritten by CLEAR.
- FSM CLEAR:
  - Each cycle writes 0 to word[index]; index increments.
  - When index==DEPTH-1 is written -> READY next cycle, stat_busy=0.
  - Duration is exactly DEPTH cycles after reset deassert.
- FSM READY:
  - ctrl_clear=1 -> CLEAR with index=0; the request presented in that same cycle is still serviced.
  - Reset asserted mid-CLEAR restarts CLEAR from index 0.
- Access accepted: READY and bram_en=1 and bram_addr<DEPTH.
  - Write: any we bit set. Byte lane b is updated from din[8b+7:8b] iff we[b]=1; stat_wr_count+1.
  - Read: we=0. stat_rd_count+1.
- Read latency:
  - Accepted read at cycle t -> bram_dout carries word[addr] at cycle t+READ_LATENCY.
  - Data is captured at cycle t, so the pipeline carries data, not addresses.
  - Back-to-back reads give one word per cycle.
- bram_dout holds its last value when no read completes; it never returns to 0 except on reset.
- Read-first collision: only same-port write+read in one cycle is possible (write has priority over the read intent, since we!=0 means write). A read at t+1 of an address written at t returns the new data.
- Out of range (addr>=DEPTH with en=1):
  - No storage change, no counter change, stat_err<=1.
  - Read form still completes after READ_LATENCY with data 0.
- en=1 while busy: ignored, stat_err<=1, no dout update.
- stat_err_clr and a same-cycle error: set wins.
- Counters saturate at all-ones and never wrap.
- en=0: we, addr and din are don't-care.

Decomposition:
- Shared package axis_bram_pkg holds:
  - the FSM encodings (E_AXIS_BRAM_RSP_CLEAR, E_AXIS_BRAM_RSP_READY),
  - the all-ones and all-zeros byte-enable constants shared with axis_bram.
- One sub-module axis_bram_rsp_delay: parameterised valid+data shift register of depth READ_LATENCY, asynchronous reset of valid bits only.
- Storage is an inferred array inside the top.

Test Plan:
- Reset, deassert, DEPTH=16 -> stat_busy=1 for exactly 16 cycles; reading addr 0..15 afterwards returns 0; both counters 0.
- LATENCY=3: write 0x1122334455667788 to addr 5 (we=0xFF), then read addr 5 at cycle t -> dout=0x1122334455667788 at t+3, unchanged at t+4 and t+5.
- Partial write: we=0x0F, din=0xAAAAAAAAAAAAAAAA onto word 0x1122334455667788 -> readback 0x11223344AAAAAAAA; stat_wr_count=2.
- Burst: 8 consecutive reads of addrs 0..7 preloaded with i*3 -> dout sequence 0,3,...,21 on consecutive cycles; stat_rd_count=8.
- DEPTH=16, read addr 20 -> stat_err=1, dout=0 after latency, rd_count unchanged; stat_err_clr -> 0.
- ctrl_clear pulse, then en=1 during busy -> access ignored, stat_err=1; after 16 cycles all words read 0. Reset asserted mid-clear -> busy restarts a full 16 cycles.
